// File: rtl/window_serializer_if.sv
// rtl/window_serializer_if.sv - load and serial handshake bundle for window_serializer
interface window_serializer_if #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32
);
  logic [SIZE*DATA_WIDTH-1:0] load_data;
  logic                       load_valid;
  logic                       load_ready;
  logic [DATA_WIDTH-1:0]      shift_out;
  logic                       shift_valid;
  logic                       shift_ready;
  logic                       last;
  logic                       busy;

  modport master (
    output load_data, load_valid, shift_ready,
    input  load_ready, shift_out, shift_valid, last, busy
  );

  modport slave (
    input  load_data, load_valid, shift_ready,
    output load_ready, shift_out, shift_valid, last, busy
  );
endinterface

// File: rtl/window_serializer.sv
// rtl/window_serializer.sv - parallel word to element stream, element SIZE-1 first
// Optional one-word preload buffer compiled in by SERIALIZER_PRELOAD_EN.
module window_serializer #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  window_serializer_if.slave  bus
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int WW = SIZE * DATA_WIDTH;
  localparam logic [CW-1:0] TOP = CW'(SIZE - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         word_q, word_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic                  shift_valid_q, shift_valid_d;
  logic                  last_q, last_d;
  logic                  load_ready_q, load_ready_d;
`ifdef SERIALIZER_PRELOAD_EN
  logic [WW-1:0]         buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
`endif

  logic load_fire;
  logic xfer;
  logic xfer_last;

  assign load_fire = bus.load_valid && load_ready_q;
  assign xfer      = shift_valid_q && bus.shift_ready;
  assign xfer_last = xfer && (count_q == '0);

  function automatic logic [DATA_WIDTH-1:0] elem(input logic [WW-1:0] w, input logic [CW-1:0] idx);
    elem = w[DATA_WIDTH*int'(idx) +: DATA_WIDTH];
  endfunction

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    count_d     = count_q;
    shift_out_d = shift_out_q;
`ifdef SERIALIZER_PRELOAD_EN
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d     = SHIFT;
          word_d      = bus.load_data;
          count_d     = TOP;
          shift_out_d = elem(bus.load_data, TOP);
        end
      end
      SHIFT: begin
        if (xfer && !xfer_last) begin
          count_d     = count_q - CW'(1);
          shift_out_d = elem(word_q, count_q - CW'(1));
        end else if (xfer_last) begin
`ifdef SERIALIZER_PRELOAD_EN
          // A buffered word wins; a load can only fire here when the buffer is empty.
          if (buf_full_q) begin
            word_d      = buf_q;
            count_d     = TOP;
            shift_out_d = elem(buf_q, TOP);
            buf_full_d  = 1'b0;
          end else if (load_fire) begin
            word_d      = bus.load_data;
            count_d     = TOP;
            shift_out_d = elem(bus.load_data, TOP);
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef SERIALIZER_PRELOAD_EN
        if (load_fire && !xfer_last) begin
          buf_d      = bus.load_data;
          buf_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    shift_valid_d = (state_d == SHIFT);
    last_d        = shift_valid_d && (count_d == '0);
`ifdef SERIALIZER_PRELOAD_EN
    load_ready_d  = !buf_full_d;
`else
    load_ready_d  = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      word_q        <= '0;
      count_q       <= '0;
      shift_out_q   <= '0;
      shift_valid_q <= 1'b0;
      last_q        <= 1'b0;
      load_ready_q  <= 1'b1;
`ifdef SERIALIZER_PRELOAD_EN
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      count_q       <= count_d;
      shift_out_q   <= shift_out_d;
      shift_valid_q <= shift_valid_d;
      last_q        <= last_d;
      load_ready_q  <= load_ready_d;
`ifdef SERIALIZER_PRELOAD_EN
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
`endif
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.shift_out   = shift_out_q;
  assign bus.shift_valid = shift_valid_q;
  assign bus.last        = last_q;
  assign bus.busy        = shift_valid_q;

endmodule

// File: tb/tb_window_serializer.sv
// tb/tb_window_serializer.sv - directed and randomized checks of window_serializer
module tb_window_serializer;
  localparam int SIZE = 3;
  localparam int DW   = 32;
  localparam int WW   = SIZE * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  window_serializer_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

  window_serializer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

`ifdef SERIALIZER_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  logic [WW-1:0] wa, wb, cw, sr;
  logic [WW-1:0] mw[$];
  logic [DW-1:0] elems[$];
  logic [DW-1:0] obs_d[8];
  logic          obs_v[8];
  logic [DW-1:0] cur_out;
  logic          fire, xfer, exp_v, exp_r;
  int            wi, k, gap, idx;

  initial begin
    bus.load_data   = '0;
    bus.load_valid  = 1'b0;
    bus.shift_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.shift_valid, 1'b0);
    chk("rst_out",   bus.shift_out, '0);
    chk("rst_last",  bus.last, 1'b0);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_ready", bus.load_ready, 1'b1);
    reset = 1'b0;
    tick();

    // Basic word, downstream always ready
    wa = {32'h33, 32'h22, 32'h11};
    bus.load_data   = wa;
    bus.load_valid  = 1'b1;
    bus.shift_ready = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int e = SIZE - 1; e >= 0; e--) begin
      chk("basic_valid", bus.shift_valid, 1'b1);
      chk("basic_data",  bus.shift_out, wa[DW*e +: DW]);
      chk("basic_last",  bus.last, (e == 0));
      chk("basic_ready", bus.load_ready, PRELOAD);
      tick();
    end
    chk("basic_end_valid", bus.shift_valid, 1'b0);
    chk("basic_end_hold",  bus.shift_out, 32'h11);
    chk("basic_end_ready", bus.load_ready, 1'b1);
    chk("basic_end_busy",  bus.busy, 1'b0);

    // Backpressure for four cycles
    bus.load_valid  = 1'b1;
    bus.shift_ready = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_valid", bus.shift_valid, 1'b1);
      chk("bp_hold_data",  bus.shift_out, 32'h33);
      chk("bp_hold_last",  bus.last, 1'b0);
      tick();
    end
    chk("bp_n5_data", bus.shift_out, 32'h33);
    bus.shift_ready = 1'b1;
    tick();
    chk("bp_e1", bus.shift_out, 32'h22);
    chk("bp_e1_last", bus.last, 1'b0);
    tick();
    chk("bp_e0", bus.shift_out, 32'h11);
    chk("bp_e0_last", bus.last, 1'b1);
    tick();
    chk("bp_end_valid", bus.shift_valid, 1'b0);

    // Reset while 0x22 is presented
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("rs_e2", bus.shift_out, 32'h33);
    tick();
    chk("rs_e1", bus.shift_out, 32'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_valid", bus.shift_valid, 1'b0);
    chk("rs_out",   bus.shift_out, '0);
    chk("rs_ready", bus.load_ready, 1'b1);
    chk("rs_last",  bus.last, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rs_quiet_valid", bus.shift_valid, 1'b0);
      chk("rs_quiet_out",   bus.shift_out, '0);
    end

    // Reset wins over a simultaneous load
    reset = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus.load_valid = 1'b0;
    chk("rsld_valid", bus.shift_valid, 1'b0);
    chk("rsld_ready", bus.load_ready, 1'b1);
    tick();
    chk("rsld_valid2", bus.shift_valid, 1'b0);

    // Two words back to back with load_valid held
    wb = {$urandom, $urandom, $urandom};
    elems.delete();
    for (int e = SIZE - 1; e >= 0; e--) elems.push_back(wa[DW*e +: DW]);
    for (int e = SIZE - 1; e >= 0; e--) elems.push_back(wb[DW*e +: DW]);
    wi = 0;
    bus.load_data   = wa;
    bus.load_valid  = 1'b1;
    bus.shift_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      fire = bus.load_valid && bus.load_ready;
      tick();
      if (fire) begin
        wi++;
        if (wi < 2) bus.load_data = wb;
        else        bus.load_valid = 1'b0;
      end
      obs_v[c] = bus.shift_valid;
      obs_d[c] = bus.shift_out;
    end
    gap = PRELOAD ? -1 : SIZE;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == gap || k >= 2 * SIZE) begin
        chk("b2b_valid", obs_v[c], 1'b0);
      end else begin
        chk("b2b_valid", obs_v[c], 1'b1);
        chk("b2b_data",  obs_d[c], elems[k]);
        k++;
      end
    end

    // Randomized traffic against a word-queue model with loopback register
    reset = 1'b1;
    bus.load_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mw.delete();
    idx = SIZE - 1;
    sr = '0;
    for (int c = 0; c < 500; c++) begin
      exp_v = (mw.size() > 0);
      exp_r = PRELOAD ? (mw.size() < 2) : (mw.size() == 0);
      chk("r_valid", bus.shift_valid, exp_v);
      chk("r_busy",  bus.busy, exp_v);
      chk("r_ready", bus.load_ready, exp_r);
      if (exp_v) begin
        cw = mw[0];
        chk("r_data", bus.shift_out, cw[DW*idx +: DW]);
        chk("r_last", bus.last, (idx == 0));
      end
      if (!bus.load_valid && c < 470 && $urandom_range(0, 2) != 0) begin
        bus.load_valid = 1'b1;
        bus.load_data  = {$urandom, $urandom, $urandom};
      end
      bus.shift_ready = ($urandom_range(0, 3) != 0);
      fire    = bus.load_valid && exp_r;
      xfer    = exp_v && bus.shift_ready;
      cur_out = bus.shift_out;
      tick();
      if (xfer) begin
        sr = {sr[WW-DW-1:0], cur_out};
        if (idx == 0) begin
          chk("r_loopback", sr, mw[0]);
          void'(mw.pop_front());
          idx = SIZE - 1;
        end else begin
          idx--;
        end
      end
      if (fire) begin
        mw.push_back(bus.load_data);
        if (c < 470 && $urandom_range(0, 1) == 1) bus.load_data = {$urandom, $urandom, $urandom};
        else                                      bus.load_valid = 1'b0;
      end
    end
    chk("r_drained", bus.shift_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
